audio_block_processor: RTL and testbench
========================================

// Module: audio_block_processor
// PURPOSE
//  Parametrised successor of the block-processing top: accepts one flattened multi-channel audio
//  buffer, applies a per-channel gain/mode op one sample per cycle with saturation, and publishes
//  the finished buffer plus peak/clip stats with a single-cycle done pulse. Sits between the
//  capture buffer and the output/DAC buffer; read_buffer only ever holds a complete processed block.
// PARAMETERS
//  BUFF_SIZE    4   frames per block
//  CHANNELS     2   interleaved channels per frame
//  SAMPLE_SIZE  16  signed sample width
//  GAIN_WIDTH   16  signed per-channel gain width
//  GAIN_FRAC    14  fractional bits of gain (1.0 = 1<<GAIN_FRAC)
//  (derived N = BUFF_SIZE*CHANNELS samples; BW = N*SAMPLE_SIZE)
// PORTS
//  clock        in   1                    single clock, all logic on rising edge
//  reset        in   1                    synchronous, active-high
//  start        in   1                    request; accepted only when busy=0
//  mode         in   2                    00 bypass, 01 gain, 10 mute, 11 invert; latched on accept
//  gain         in   CHANNELS*GAIN_WIDTH  per-channel gain, ch c at [c*GAIN_WIDTH +: GAIN_WIDTH]; latched
//  input_buffer in   BW                   sample k=frame*CHANNELS+ch at [k*SAMPLE_SIZE +: SAMPLE_SIZE]; latched
//  read_buffer  out  BW                   last completed processed block, same layout
//  busy         out  1                    high from accept edge until done edge
//  done         out  1                    one-cycle pulse, block published
//  peak         out  SAMPLE_SIZE          unsigned max |output sample| of last block
//  clip         out  1                    any sample of last block saturated
// BEHAVIOUR
//  - Reset: state IDLE, read_buffer=0, busy=0, done=0, peak=0, clip=0, index=0, internal buffers=0.
//  - FSM IDLE -> PROCESS -> DONE -> IDLE.
//  - Edge E0, IDLE & start: latch input_buffer, gain, mode; clear running peak/clip; busy<=1; ->PROCESS.
//  - PROCESS: at edge E(i+1) sample i (i=0..N-1) written to internal write buffer; ch = i % CHANNELS;
//    after EN ->DONE.
//  - DONE, edge E(N+1): read_buffer<=write buffer, peak/clip<=running values, done<=1, busy<=0, ->IDLE.
//    Start->done latency N+1 edges. done deasserts next edge.
//  - start while busy (PROCESS/DONE) ignored, no queuing; inputs changing while busy have no effect.
//  - start sampled on the cycle done is high (state IDLE) is accepted: back-to-back blocks, no gap.
//  - Arithmetic: gain: p = s*g (SAMPLE_SIZE+GAIN_WIDTH bits signed), r = p >>> GAIN_FRAC (floor),
//    saturate to [-2^(S-1), 2^(S-1)-1]; bypass: r=s; mute: r=0; invert: r=-s, -2^(S-1)->2^(S-1)-1.
//  - clip set if any saturation occurred in block. peak = max |r|; |−2^(S-1)| cannot occur after
//    saturation except via gain/bypass, and is represented as unsigned 2^(S-1) (fits S bits).
//  - read_buffer/peak/clip change only on the done edge; hold between blocks.
//  - reset mid-block: abort, no done pulse, outputs return to reset values.
// STRUCTURE
//  - audio_proc_pkg: mode_t enum (BYPASS/GAIN/MUTE/INVERT), state_t enum (IDLE/PROCESS/DONE),
//    function sat_s(value, width) for signed saturation.
//  - Sub-module audio_sample_op: combinational sample x gain x mode -> result, saturated flag, |result|.
//  - Top: FSM, index counter ($clog2(N) bits), latched input/gain/mode, write buffer, stats regs.
// TESTING (defaults; 1.0 gain = 16'h4000)
//  1. bypass, samples k+1 (1..8), start 1 cycle -> read_buffer=1..8, done exactly 9 edges after
//     accept, busy high 9 cycles, peak=8, clip=0.
//  2. gain ch0=16'h2000, ch1=16'h7FFF, ch0 samples 1000, ch1 samples 20000 -> ch0 500, ch1 32767,
//     clip=1, peak=32767.
//  3. invert, samples {-32768,5,-7,0,...} -> {32767,-5,7,0,...}, clip=1; gain 0.5 on -3 -> -2 (floor).
//  4. mute with nonzero data -> all 0, peak=0, clip=0; prior read_buffer held until this done edge.
//  5. start pulsed mid-block with new data -> ignored, result equals first block; then reset at
//     index 3 -> no done, read_buffer=0, busy=0, next start processes normally.
//  6. start held high continuously -> new block accepted on each done cycle, done every 10 cycles.

Source files
------------

// File: rtl/audio_proc_pkg.sv
// Shared types and helpers for the audio block processor.
//   mode_t  : per-block sample operation (bypass / gain / mute / invert)
//   state_t : block sequencing states
//   sat_s   : clamp a wide signed value into a signed range of a given width
package audio_proc_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'b00,
        GAIN   = 2'b01,
        MUTE   = 2'b10,
        INVERT = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PROCESS = 2'b01,
        DONE    = 2'b10
    } state_t;

    // Values are carried as 64-bit signed so one helper serves every sample width.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] value,
                                                 input int unsigned        width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/audio_sample_op.sv
// Combinational single-sample operation.
//   sample    : signed input sample
//   gain_val  : signed gain, GAIN_FRAC fractional bits
//   mode      : operation to apply
//   result    : saturated signed result
//   saturated : result was clamped
//   magnitude : |result| as unsigned (the most negative value maps to 2^(S-1))
module audio_sample_op
    import audio_proc_pkg::*;
#(
    parameter int SAMPLE_SIZE = 16,
    parameter int GAIN_WIDTH  = 16,
    parameter int GAIN_FRAC   = 14
) (
    input  logic signed [SAMPLE_SIZE-1:0] sample,
    input  logic signed [GAIN_WIDTH-1:0]  gain_val,
    input  mode_t                         mode,
    output logic signed [SAMPLE_SIZE-1:0] result,
    output logic                          saturated,
    output logic        [SAMPLE_SIZE-1:0] magnitude
);

    logic signed [SAMPLE_SIZE+GAIN_WIDTH-1:0] product;
    logic signed [SAMPLE_SIZE+GAIN_WIDTH-1:0] scaled;
    logic signed [63:0]                       pre_sat;
    logic signed [63:0]                       post_sat;

    always_comb begin
        product = sample * gain_val;
        // Arithmetic shift floors toward minus infinity.
        scaled  = product >>> GAIN_FRAC;
        pre_sat = 64'(sample);
        unique case (mode)
            BYPASS: pre_sat = 64'(sample);
            GAIN:   pre_sat = 64'(scaled);
            MUTE:   pre_sat = '0;
            INVERT: pre_sat = -64'(sample);
        endcase
        post_sat  = sat_s(pre_sat, SAMPLE_SIZE);
        result    = post_sat[SAMPLE_SIZE-1:0];
        saturated = (post_sat != pre_sat);
        magnitude = result[SAMPLE_SIZE-1] ? SAMPLE_SIZE'(-result) : SAMPLE_SIZE'(result);
    end

endmodule

// File: rtl/audio_block_processor.sv
// Block processor: latches one multi-channel buffer, applies the selected
// per-channel operation one sample per cycle, then publishes the block with
// peak/clip stats and a one-cycle done pulse.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   start         : block request, taken only while idle
//   mode, gain    : operation and per-channel gains, latched on accept
//   input_buffer  : flattened interleaved samples, latched on accept
//   read_buffer   : last completed block
//   busy, done    : in-flight flag and publish pulse
//   peak, clip    : max |sample| and saturation flag of last block
//
// state   | meaning
// IDLE    | waiting for start; done pulse (if any) is high here
// PROCESS | one sample per cycle into the write buffer
// DONE    | publish write buffer and stats
module audio_block_processor
    import audio_proc_pkg::*;
#(
    parameter int BUFF_SIZE   = 4,
    parameter int CHANNELS    = 2,
    parameter int SAMPLE_SIZE = 16,
    parameter int GAIN_WIDTH  = 16,
    parameter int GAIN_FRAC   = 14
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [1:0]                             mode,
    input  logic [CHANNELS*GAIN_WIDTH-1:0]         gain,
    input  logic [BUFF_SIZE*CHANNELS*SAMPLE_SIZE-1:0] input_buffer,
    output logic [BUFF_SIZE*CHANNELS*SAMPLE_SIZE-1:0] read_buffer,
    output logic                                   busy,
    output logic                                   done,
    output logic [SAMPLE_SIZE-1:0]                 peak,
    output logic                                   clip
);

    localparam int N  = BUFF_SIZE * CHANNELS;
    localparam int BW = N * SAMPLE_SIZE;
    localparam int GW = CHANNELS * GAIN_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t                 state_q, state_d;
    logic [IW-1:0]          index_q, index_d;
    logic [BW-1:0]          in_buf_q, in_buf_d;
    logic [GW-1:0]          gain_q, gain_d;
    mode_t                  mode_q, mode_d;
    logic [BW-1:0]          wr_buf_q, wr_buf_d;
    logic [BW-1:0]          read_buffer_q, read_buffer_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [SAMPLE_SIZE-1:0] peak_q, peak_d;
    logic [SAMPLE_SIZE-1:0] run_peak_q, run_peak_d;
    logic                   clip_q, clip_d;
    logic                   run_clip_q, run_clip_d;

    int                            ch_sel;
    logic signed [SAMPLE_SIZE-1:0] cur_sample;
    logic signed [GAIN_WIDTH-1:0]  cur_gain;
    logic signed [SAMPLE_SIZE-1:0] op_result;
    logic                          op_sat;
    logic        [SAMPLE_SIZE-1:0] op_mag;

    always_comb begin
        ch_sel     = int'(index_q) % CHANNELS;
        cur_sample = in_buf_q[index_q*SAMPLE_SIZE +: SAMPLE_SIZE];
        cur_gain   = gain_q[ch_sel*GAIN_WIDTH +: GAIN_WIDTH];
    end

    audio_sample_op #(
        .SAMPLE_SIZE (SAMPLE_SIZE),
        .GAIN_WIDTH  (GAIN_WIDTH),
        .GAIN_FRAC   (GAIN_FRAC)
    ) u_sample_op (
        .sample    (cur_sample),
        .gain_val  (cur_gain),
        .mode      (mode_q),
        .result    (op_result),
        .saturated (op_sat),
        .magnitude (op_mag)
    );

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        in_buf_d      = in_buf_q;
        gain_d        = gain_q;
        mode_d        = mode_q;
        wr_buf_d      = wr_buf_q;
        read_buffer_d = read_buffer_q;
        busy_d        = busy_q;
        done_d        = done_q;
        peak_d        = peak_q;
        run_peak_d    = run_peak_q;
        clip_d        = clip_q;
        run_clip_d    = run_clip_q;

        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                // Accepting here while done is high gives gap-free back-to-back blocks.
                if (start) begin
                    in_buf_d   = input_buffer;
                    gain_d     = gain;
                    mode_d     = mode_t'(mode);
                    run_peak_d = '0;
                    run_clip_d = 1'b0;
                    index_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = PROCESS;
                end
            end
            PROCESS: begin
                wr_buf_d[index_q*SAMPLE_SIZE +: SAMPLE_SIZE] = op_result;
                run_peak_d = (op_mag > run_peak_q) ? op_mag : run_peak_q;
                run_clip_d = run_clip_q | op_sat;
                if (index_q == IW'(N - 1)) begin
                    index_d = '0;
                    state_d = DONE;
                end else begin
                    index_d = index_q + IW'(1);
                end
            end
            DONE: begin
                read_buffer_d = wr_buf_q;
                peak_d        = run_peak_q;
                clip_d        = run_clip_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            index_q       <= '0;
            in_buf_q      <= '0;
            gain_q        <= '0;
            mode_q        <= BYPASS;
            wr_buf_q      <= '0;
            read_buffer_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            peak_q        <= '0;
            run_peak_q    <= '0;
            clip_q        <= 1'b0;
            run_clip_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            in_buf_q      <= in_buf_d;
            gain_q        <= gain_d;
            mode_q        <= mode_d;
            wr_buf_q      <= wr_buf_d;
            read_buffer_q <= read_buffer_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            peak_q        <= peak_d;
            run_peak_q    <= run_peak_d;
            clip_q        <= clip_d;
            run_clip_q    <= run_clip_d;
        end
    end

    assign read_buffer = read_buffer_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign peak        = peak_q;
    assign clip        = clip_q;

endmodule

// File: tb/tb_audio_block_processor.sv
module tb_audio_block_processor;

    localparam int BS = 4;
    localparam int C  = 2;
    localparam int S  = 16;
    localparam int GW = 16;
    localparam int GF = 14;
    localparam int N  = BS * C;
    localparam int BW = N * S;

    localparam logic [1:0] M_BYP = 2'b00;
    localparam logic [1:0] M_GAIN = 2'b01;
    localparam logic [1:0] M_MUTE = 2'b10;
    localparam logic [1:0] M_INV = 2'b11;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [C*GW-1:0] gain = '0;
    logic [BW-1:0]   input_buffer = '0;
    logic [BW-1:0]   read_buffer;
    logic            busy;
    logic            done;
    logic [S-1:0]    peak;
    logic            clip;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] exp_buf;
    logic [S-1:0]  exp_peak;
    logic          exp_clip;

    audio_block_processor #(
        .BUFF_SIZE   (BS),
        .CHANNELS    (C),
        .SAMPLE_SIZE (S),
        .GAIN_WIDTH  (GW),
        .GAIN_FRAC   (GF)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .gain         (gain),
        .input_buffer (input_buffer),
        .read_buffer  (read_buffer),
        .busy         (busy),
        .done         (done),
        .peak         (peak),
        .clip         (clip)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: plain integer arithmetic with explicit floor division.
    function automatic int model_sample(input int s, input int g, input logic [1:0] m,
                                        output bit sat);
        longint v;
        longint p;
        longint one;
        one = longint'(1) << GF;
        sat = 1'b0;
        v   = 0;
        case (m)
            M_BYP:  v = s;
            M_GAIN: begin
                p = longint'(s) * longint'(g);
                v = p / one;
                if (p < 0 && (p % one) != 0) v = v - 1;
            end
            M_MUTE: v = 0;
            default: v = -longint'(s);
        endcase
        if (v > 32767) begin
            v = 32767;
            sat = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            sat = 1'b1;
        end
        return int'(v);
    endfunction

    task automatic model_block(input logic [BW-1:0] b, input logic [C*GW-1:0] g,
                               input logic [1:0] m);
        int s, gv, r, mag;
        bit sat;
        exp_buf  = '0;
        exp_peak = '0;
        exp_clip = 1'b0;
        for (int k = 0; k < N; k++) begin
            s   = int'($signed(b[k*S +: S]));
            gv  = int'($signed(g[(k % C)*GW +: GW]));
            r   = model_sample(s, gv, m, sat);
            exp_buf[k*S +: S] = r[S-1:0];
            mag = (r < 0) ? -r : r;
            if (mag > int'(exp_peak)) exp_peak = mag[S-1:0];
            if (sat) exp_clip = 1'b1;
        end
    endtask

    function automatic logic [BW-1:0] rand_buf();
        logic [BW-1:0] b;
        int sel;
        for (int k = 0; k < N; k++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: b[k*S +: S] = 16'h8000;
                1: b[k*S +: S] = 16'h7FFF;
                2: b[k*S +: S] = 16'(-3);
                default: b[k*S +: S] = 16'($urandom);
            endcase
        end
        return b;
    endfunction

    // Called just after the accept edge; counts edges until done.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 50) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic start_and_wait(input logic [1:0] m, input logic [C*GW-1:0] g,
                                  input logic [BW-1:0] b, output int lat, output int busy_cnt);
        mode = m;
        gain = g;
        input_buffer = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, busy_cnt);
    endtask

    task automatic check_result(input string name);
        checks++;
        if (read_buffer !== exp_buf) begin
            errors++;
            $display("FAIL %s buffer: got %h expected %h", name, read_buffer, exp_buf);
        end
        checks++;
        if (peak !== exp_peak) begin
            errors++;
            $display("FAIL %s peak: got %0d expected %0d", name, peak, exp_peak);
        end
        checks++;
        if (clip !== exp_clip) begin
            errors++;
            $display("FAIL %s clip: got %0b expected %0b", name, clip, exp_clip);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (read_buffer !== '0) begin errors++; $display("FAIL reset read_buffer: got %h expected 0", read_buffer); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        checks++;
        if (peak !== '0) begin errors++; $display("FAIL reset peak: got %0d expected 0", peak); end
        checks++;
        if (clip !== 1'b0) begin errors++; $display("FAIL reset clip: got %b expected 0", clip); end
    endtask

    task automatic test_bypass();
        logic [BW-1:0] b;
        int lat, bc;
        for (int k = 0; k < N; k++) b[k*S +: S] = 16'(k + 1);
        model_block(b, {16'h4000, 16'h4000}, M_BYP);
        start_and_wait(M_BYP, {16'h4000, 16'h4000}, b, lat, bc);
        checks++;
        if (lat != 9) begin errors++; $display("FAIL bypass latency: got %0d expected 9", lat); end
        checks++;
        if (bc != 9) begin errors++; $display("FAIL bypass busy_cycles: got %0d expected 9", bc); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bypass busy_at_done: got %b expected 0", busy); end
        check_result("bypass");
        checks++;
        if (peak !== 16'd8) begin errors++; $display("FAIL bypass peak8: got %0d expected 8", peak); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL bypass done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_gain();
        logic [BW-1:0] b;
        logic [C*GW-1:0] g;
        int lat, bc;
        for (int f = 0; f < BS; f++) begin
            b[(f*C)*S +: S]     = 16'd1000;
            b[(f*C + 1)*S +: S] = 16'd20000;
        end
        g = {16'h7FFF, 16'h2000};
        model_block(b, g, M_GAIN);
        start_and_wait(M_GAIN, g, b, lat, bc);
        check_result("gain");
        checks++;
        if (read_buffer[15:0] !== 16'd500 || read_buffer[31:16] !== 16'd32767) begin
            errors++;
            $display("FAIL gain ch_values: got %0d,%0d expected 500,32767", read_buffer[15:0], read_buffer[31:16]);
        end
    endtask

    task automatic test_invert();
        logic [BW-1:0] b;
        logic [C*GW-1:0] g;
        int lat, bc;
        b = '0;
        b[15:0]  = 16'h8000;
        b[31:16] = 16'd5;
        b[47:32] = 16'(-7);
        g = {16'h4000, 16'h4000};
        model_block(b, g, M_INV);
        start_and_wait(M_INV, g, b, lat, bc);
        check_result("invert");
        checks++;
        if (read_buffer[15:0] !== 16'h7FFF || clip !== 1'b1) begin
            errors++;
            $display("FAIL invert min_sat: got %h clip %b expected 7fff clip 1", read_buffer[15:0], clip);
        end
        for (int k = 0; k < N; k++) b[k*S +: S] = 16'(-3);
        g = {16'h2000, 16'h2000};
        model_block(b, g, M_GAIN);
        start_and_wait(M_GAIN, g, b, lat, bc);
        check_result("gain_floor");
        checks++;
        if (read_buffer[15:0] !== 16'hFFFE) begin
            errors++;
            $display("FAIL gain_floor value: got %h expected fffe", read_buffer[15:0]);
        end
    endtask

    task automatic test_mute();
        logic [BW-1:0] b;
        logic [BW-1:0] prev;
        logic [C*GW-1:0] g;
        int lat, bc, held_bad;
        prev = exp_buf;
        b = rand_buf();
        g = {16'($urandom), 16'($urandom)};
        model_block(b, g, M_MUTE);
        mode = M_MUTE;
        gain = g;
        input_buffer = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        held_bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (read_buffer !== prev) held_bad++;
            tick();
        end
        checks++;
        if (held_bad != 0) begin errors++; $display("FAIL mute hold_prev: got %0d changed cycles expected 0", held_bad); end
        wait_done(lat, bc);
        check_result("mute");
        checks++;
        if (read_buffer !== '0 || peak !== '0) begin
            errors++;
            $display("FAIL mute zero: got %h peak %0d expected 0", read_buffer, peak);
        end
    endtask

    task automatic test_ignore_and_reset();
        logic [BW-1:0] b;
        logic [C*GW-1:0] g;
        int lat, bc, seen_done;
        b = rand_buf();
        g = {16'($urandom), 16'($urandom)};
        model_block(b, g, M_GAIN);
        mode = M_GAIN;
        gain = g;
        input_buffer = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        input_buffer = rand_buf();
        gain = {16'($urandom), 16'($urandom)};
        mode = M_INV;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, bc);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL ignore latency: got %0d expected 5", lat); end
        check_result("ignore");
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore no_queue: got busy %b expected 0", busy); end

        start_and_wait(M_BYP, g, rand_buf(), lat, bc);
        mode = M_GAIN;
        gain = g;
        input_buffer = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort flags: got busy %b done %b expected 0 0", busy, done);
        end
        checks++;
        if (read_buffer !== '0 || peak !== '0 || clip !== 1'b0) begin
            errors++;
            $display("FAIL abort outputs: got %h peak %0d clip %b expected zeros", read_buffer, peak, clip);
        end
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) seen_done++;
            tick();
        end
        checks++;
        if (seen_done != 0) begin errors++; $display("FAIL abort quiet: got %0d active cycles expected 0", seen_done); end
        start_and_wait(M_GAIN, g, b, lat, bc);
        checks++;
        if (lat != 9) begin errors++; $display("FAIL after_reset latency: got %0d expected 9", lat); end
        check_result("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] b;
        logic [C*GW-1:0] g;
        int done_cycles[$];
        int cyc;
        b = rand_buf();
        g = {16'($urandom), 16'($urandom)};
        model_block(b, g, M_GAIN);
        tick();
        mode = M_GAIN;
        gain = g;
        input_buffer = b;
        start = 1'b1;
        cyc = 0;
        while (done_cycles.size() < 4 && cyc < 80) begin
            tick();
            cyc++;
            if (done) begin
                done_cycles.push_back(cyc);
                checks++;
                if (read_buffer !== exp_buf) begin
                    errors++;
                    $display("FAIL b2b buffer: got %h expected %h", read_buffer, exp_buf);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (done_cycles.size() != 4) begin
            errors++;
            $display("FAIL b2b done_count: got %0d expected 4", done_cycles.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (done_cycles[i] - done_cycles[i-1] != 10) begin
                    errors++;
                    $display("FAIL b2b period: got %0d expected 10", done_cycles[i] - done_cycles[i-1]);
                end
            end
        end
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [BW-1:0] b;
        logic [C*GW-1:0] g;
        logic [1:0] m;
        int lat, bc;
        for (int t = 0; t < 20; t++) begin
            b = rand_buf();
            g = {16'($urandom), 16'($urandom)};
            m = 2'($urandom_range(0, 3));
            model_block(b, g, m);
            start_and_wait(m, g, b, lat, bc);
            checks++;
            if (lat != 9) begin errors++; $display("FAIL random latency: got %0d expected 9", lat); end
            check_result("random");
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_gain();
        test_invert();
        test_mute();
        test_ignore_and_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
